parking_counter_multi: RTL and testbench
========================================

PARKING_COUNTER_MULTI -- requirements
Module: parking_counter_multi

Interface
REQ-001 Parameter N_LANES, default 2, number of independent gate lanes (1..8).
REQ-002 Parameter CAPACITY, default 100, maximum occupancy (1..1023).
REQ-003 Localparam CW = $clog2(CAPACITY+1), the occupancy count width.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a  input  N_LANES  outer sensor per lane (1 = beam blocked); SHALL be already synchronous to clk.
REQ-007 b  input  N_LANES  inner sensor per lane (1 = beam blocked); SHALL be already synchronous to clk.
REQ-008 enter  output  N_LANES  one-cycle pulse per completed entry, per lane.
REQ-009 exit  output  N_LANES  one-cycle pulse per completed exit, per lane.
REQ-010 abort  output  N_LANES  one-cycle pulse when a lane detects an illegal sensor sequence.
REQ-011 count  output  CW  current occupancy.
REQ-012 full / empty  output  1 each  count==CAPACITY / count==0.
REQ-013 over_err / under_err  output  1 each  one-cycle pulse on saturation at CAPACITY / at 0.

Function
REQ-014 Each lane SHALL run an independent FSM: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, ABORT; {a,b} per lane selects the transition.
REQ-015 IDLE: 10->EN_A; 01->EX_B; 11->ABORT; 00->stay.
REQ-016 EN_A: 10->stay; 11->EN_AB; 00->IDLE with no pulse (car backed out); 01->ABORT.
REQ-017 EN_AB: 11->stay; 01->EN_B; 10->EN_A (reversal); 00->ABORT.
REQ-018 EN_B: 01->stay; 11->EN_AB; 00->IDLE and enter pulse; 10->ABORT.
REQ-019 EX_B, EX_AB, EX_A SHALL mirror REQ-016..018 with a and b swapped; EX_A on 00 -> IDLE and exit pulse.
REQ-020 ABORT: 00->IDLE; otherwise stay; the abort pulse SHALL fire only on entry to ABORT.
REQ-021 enter, exit and abort SHALL be registered and high for exactly one cycle, in the cycle after the edge that takes the transition.
REQ-022 count SHALL update on the edge after the pulse cycle, so latency is 2 cycles from the sampled 00 to count change.
REQ-023 Per cycle: raw = count + popcount(enter) - popcount(exit), computed signed at CW+4 bits.
REQ-024 Simultaneous entries and exits on any lanes SHALL be netted in the same cycle.
REQ-025 If raw > CAPACITY: count <= CAPACITY and over_err pulses.
REQ-026 If raw < 0: count <= 0 and under_err pulses.
REQ-027 Otherwise count <= raw and neither error flag asserts.
REQ-028 full and empty SHALL be decoded from the count register with no extra latency.
REQ-029 Lanes SHALL NOT interact except through the shared counter.

Reset
REQ-030 While reset is high at a clock edge, all lane FSMs SHALL go to IDLE and count <= 0.
REQ-031 Under the same condition, enter, exit, abort, over_err and under_err SHALL go to 0; hence empty=1 and full=0.
REQ-032 Reset mid-sequence SHALL discard the partial sequence; no pulse SHALL be generated for it.
REQ-033 Sensor inputs SHALL be ignored during reset; evaluation SHALL resume on the first edge after reset deasserts.

Structure
REQ-034 Package parking_pkg SHALL hold the lane_state_t enum and the default values of N_LANES and CAPACITY.
REQ-035 Sub-module lane_detector (clk, reset, a, b -> enter, exit, abort) SHALL be instantiated N_LANES times via generate.
REQ-036 Counter, saturation and flag logic SHALL live in the top level.

Verification
REQ-037 Lane0 {a,b} 00,10,11,01,00 (one cycle each) -> enter[0] pulses once, count 0->1, empty falls.
REQ-038 Lane1 01,11,10,00 from count=1 -> exit[1] pulses once, count 1->0, empty=1; then a further exit -> count stays 0 and under_err pulses.
REQ-039 Lane0 00,10,00 (back-out) -> no enter pulse, count unchanged; lane0 00,11,00 -> abort[0] pulses once, count unchanged.
REQ-040 At count=5, lane0 entry and lane1 exit completing on the same edge -> enter[0] and exit[1] coincide, count stays 5.
REQ-041 CAPACITY=3, four sequential entries -> count 1,2,3,3; full=1 after the third; over_err on the fourth.
REQ-042 Reset asserted while lane0 is in EN_AB, then sequence 01,00 -> no enter pulse, count=0.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the multi-lane parking counter.
//   lane_state_t  : per-lane gate sequence states
//   N_LANES_DEF   : default number of gate lanes
//   CAPACITY_DEF  : default maximum occupancy
package parking_pkg;

  localparam int N_LANES_DEF  = 2;
  localparam int CAPACITY_DEF = 100;

  // EN_* track a car travelling outer->inner (entry).
  // EX_* track a car travelling inner->outer (exit).
  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_AB,
    EX_A,
    ABORT
  } lane_state_t;

endpackage

// File: rtl/parking_counter_multi_if.sv
// Sensor/status bundle of the parking counter.
//   a, b              : per-lane outer/inner beam sensors (1 = blocked)
//   enter, exit, abort: per-lane one-cycle event pulses
//   count             : current occupancy
//   full, empty       : occupancy at CAPACITY / at 0
//   over_err/under_err: one-cycle saturation pulses
// master = sensor/monitor side, slave = counter side.
interface parking_counter_multi_if #(
  parameter int N_LANES  = parking_pkg::N_LANES_DEF,
  parameter int CAPACITY = parking_pkg::CAPACITY_DEF
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic [N_LANES-1:0] a;
  logic [N_LANES-1:0] b;
  logic [N_LANES-1:0] enter;
  logic [N_LANES-1:0] exit;
  logic [N_LANES-1:0] abort;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               over_err;
  logic               under_err;

  modport master (
    output a, b,
    input  enter, exit, abort, count, full, empty, over_err, under_err
  );

  modport slave (
    input  a, b,
    output enter, exit, abort, count, full, empty, over_err, under_err
  );
endinterface

// File: rtl/lane_detector.sv
// One gate lane: follows the outer (a) / inner (b) beam sequence and emits
// registered one-cycle pulses for a completed entry, a completed exit, or an
// illegal sequence.
//   clk, reset : clock, synchronous active-high reset
//   a, b       : outer / inner sensor, already synchronous to clk
//   enter      : pulse after the final 00 of an outer->inner passage
//   exit       : pulse after the final 00 of an inner->outer passage
//   abort      : pulse on entry to the ABORT state
module lane_detector
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit,
  output logic abort
);

  lane_state_t state_q, state_d;
  logic        enter_d, exit_d, abort_d;
  logic [1:0]  ab;

  assign ab = {a, b};

  // NOTE: state and pulse registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state_q <= state_d;
      enter   <= enter_d;
      exit    <= exit_d;
      abort   <= abort_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = EN_A;
        2'b01:   state_d = EX_B;
        2'b11:   state_d = ABORT;
        default: state_d = IDLE;
      endcase
      EN_A: case (ab)
        2'b11:   state_d = EN_AB;
        2'b00:   state_d = IDLE;   // car backed out
        2'b01:   state_d = ABORT;
        default: state_d = EN_A;
      endcase
      EN_AB: case (ab)
        2'b01:   state_d = EN_B;
        2'b10:   state_d = EN_A;   // reversal
        2'b00:   state_d = ABORT;
        default: state_d = EN_AB;
      endcase
      EN_B: case (ab)
        2'b11:   state_d = EN_AB;
        2'b00: begin
          state_d = IDLE;
          enter_d = 1'b1;
        end
        2'b10:   state_d = ABORT;
        default: state_d = EN_B;
      endcase
      EX_B: case (ab)
        2'b11:   state_d = EX_AB;
        2'b00:   state_d = IDLE;   // car backed out
        2'b10:   state_d = ABORT;
        default: state_d = EX_B;
      endcase
      EX_AB: case (ab)
        2'b10:   state_d = EX_A;
        2'b01:   state_d = EX_B;   // reversal
        2'b00:   state_d = ABORT;
        default: state_d = EX_AB;
      endcase
      EX_A: case (ab)
        2'b11:   state_d = EX_AB;
        2'b00: begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end
        2'b01:   state_d = ABORT;
        default: state_d = EX_A;
      endcase
      ABORT:   state_d = (ab == 2'b00) ? IDLE : ABORT;
      default: state_d = IDLE;
    endcase
    // Fires only on the transition into ABORT, not while parked there.
    abort_d = (state_d == ABORT) && (state_q != ABORT);
  end

endmodule

// File: rtl/parking_counter_multi.sv
// Multi-lane parking occupancy counter. One lane_detector per gate; the
// per-lane enter/exit pulses are netted each cycle into a saturating count.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sensors in, per-lane pulses, count and status flags out
module parking_counter_multi
  import parking_pkg::*;
#(
  parameter int N_LANES  = N_LANES_DEF,
  parameter int CAPACITY = CAPACITY_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_counter_multi_if.slave  bus
);

  localparam int CW = $clog2(CAPACITY + 1);
  // Four spare bits hold the signed sum of count and up to 8 lanes each way.
  localparam int RW = CW + 4;
  localparam logic signed [RW-1:0] CAP_S = RW'(CAPACITY);

  logic [N_LANES-1:0]    enter_v, exit_v, abort_v;
  logic [RW-1:0]         n_enter, n_exit;
  logic signed [RW-1:0]  raw;
  logic [CW-1:0]         count_q;
  logic                  over_q, under_q;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_detector u_lane (
      .clk   (clk),
      .reset (reset),
      .a     (bus.a[i]),
      .b     (bus.b[i]),
      .enter (enter_v[i]),
      .exit  (exit_v[i]),
      .abort (abort_v[i])
    );
  end

  // Counter consumes the registered lane pulses, so count moves one edge
  // after the pulse cycle.
  always_comb begin
    n_enter = '0;
    n_exit  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_enter = n_enter + RW'(enter_v[i]);
      n_exit  = n_exit  + RW'(exit_v[i]);
    end
    raw = $signed({4'b0000, count_q} + n_enter - n_exit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      over_q  <= 1'b0;
      under_q <= 1'b0;
      if (raw > CAP_S) begin
        count_q <= CW'(CAPACITY);
        over_q  <= 1'b1;
      end else if (raw < 0) begin
        count_q <= '0;
        under_q <= 1'b1;
      end else begin
        count_q <= raw[CW-1:0];
      end
    end
  end

  assign bus.enter     = enter_v;
  assign bus.exit      = exit_v;
  assign bus.abort     = abort_v;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(CAPACITY));
  assign bus.empty     = (count_q == '0);
  assign bus.over_err  = over_q;
  assign bus.under_err = under_q;

endmodule

// File: tb/tb_parking_counter_multi.sv
// Bench for parking_counter_multi: directed scenarios on a CAPACITY=100 and a
// CAPACITY=3 instance, then randomized sensor traffic against a reference
// model that describes each lane by where a passage started and where the
// car last stood on the outer/both/inner path.
module tb_parking_counter_multi;

  localparam int NL   = 2;
  localparam int CAP  = 100;
  localparam int CAP3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_counter_multi_if #(.N_LANES(NL), .CAPACITY(CAP))  bus  ();
  parking_counter_multi_if #(.N_LANES(NL), .CAPACITY(CAP3)) bus3 ();

  parking_counter_multi #(.N_LANES(NL), .CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  parking_counter_multi #(.N_LANES(NL), .CAPACITY(CAP3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_active [NL];
  bit          m_aborted[NL];
  logic [1:0]  m_origin [NL];
  logic [1:0]  m_last   [NL];
  logic [NL-1:0] m_enter, m_exit, m_abort;
  int          m_count;
  bit          m_over, m_under;

  int obs_enter[NL];
  int obs_exit [NL];
  int obs_abort[NL];

  // Position along the gate: outer only, both, inner only.
  function automatic int pos_of(input logic [1:0] s);
    case (s)
      2'b10:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input logic [NL-1:0] a, input logic [NL-1:0] b);
    int raw;
    logic [NL-1:0] e, x, k;
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        m_active[i]  = 1'b0;
        m_aborted[i] = 1'b0;
      end
      m_enter = '0; m_exit = '0; m_abort = '0;
      m_count = 0; m_over = 1'b0; m_under = 1'b0;
      return;
    end
    raw = m_count + $countones(m_enter) - $countones(m_exit);
    m_over  = (raw > CAP);
    m_under = (raw < 0);
    m_count = m_over ? CAP : (m_under ? 0 : raw);
    e = '0; x = '0; k = '0;
    for (int i = 0; i < NL; i++) begin
      logic [1:0] s;
      int d;
      s = {a[i], b[i]};
      if (m_aborted[i]) begin
        if (s == 2'b00) m_aborted[i] = 1'b0;
      end else if (!m_active[i]) begin
        if (s == 2'b11) begin
          k[i] = 1'b1; m_aborted[i] = 1'b1;
        end else if (s != 2'b00) begin
          m_active[i] = 1'b1; m_origin[i] = s; m_last[i] = s;
        end
      end else if (s == 2'b00) begin
        m_active[i] = 1'b0;
        if (m_last[i] == 2'b11) begin
          k[i] = 1'b1; m_aborted[i] = 1'b1;
        end else if (m_origin[i] == 2'b10 && m_last[i] == 2'b01) begin
          e[i] = 1'b1;
        end else if (m_origin[i] == 2'b01 && m_last[i] == 2'b10) begin
          x[i] = 1'b1;
        end
      end else begin
        d = pos_of(s) - pos_of(m_last[i]);
        if (d == 2 || d == -2) begin
          k[i] = 1'b1; m_aborted[i] = 1'b1; m_active[i] = 1'b0;
        end else begin
          m_last[i] = s;
        end
      end
    end
    m_enter = e; m_exit = x; m_abort = k;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NL; i++) begin
      obs_enter[i] = 0; obs_exit[i] = 0; obs_abort[i] = 0;
    end
  endtask

  // Drive lane patterns ({a,b} for lane0 and lane1), take one edge, sample #1 later.
  task automatic step2(input logic [1:0] p0, input logic [1:0] p1, input bit rst = 1'b0);
    logic [NL-1:0] a, b;
    a = {p1[1], p0[1]};
    b = {p1[0], p0[0]};
    bus.a = a;
    bus.b = b;
    reset = rst;
    @(posedge clk);
    model_edge(rst, a, b);
    #1;
    for (int i = 0; i < NL; i++) begin
      obs_enter[i] += int'(bus.enter[i]);
      obs_exit[i]  += int'(bus.exit[i]);
      obs_abort[i] += int'(bus.abort[i]);
    end
  endtask

  task automatic cap_step(input logic [1:0] p);
    bus3.a = {1'b0, p[1]};
    bus3.b = {1'b0, p[0]};
    step2(2'b00, 2'b00);
  endtask

  task automatic test_reset();
    bus3.a = '0; bus3.b = '0;
    step2(2'b11, 2'b10, 1'b1);
    step2(2'b01, 2'b11, 1'b1);
    n_checks++; if (bus.count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    n_checks++; if ({bus.enter, bus.exit, bus.abort} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000000", {bus.enter, bus.exit, bus.abort}); end
    n_checks++; if ({bus.over_err, bus.under_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {bus.over_err, bus.under_err}); end
    n_checks++; if (bus3.count !== 2'd0 || bus3.empty !== 1'b1) begin n_fail++; $display("FAIL reset_cap3: got count %0d empty %b expected 0 1", bus3.count, bus3.empty); end
  endtask

  task automatic test_entry();
    step2(2'b00, 2'b00, 1'b0);
    clear_obs();
    step2(2'b00, 2'b00); step2(2'b10, 2'b00); step2(2'b11, 2'b00); step2(2'b01, 2'b00);
    step2(2'b00, 2'b00);
    n_checks++; if (bus.enter[0] !== 1'b1 || bus.count !== 7'd0) begin n_fail++; $display("FAIL entry_pulse: got enter %b count %0d expected 1 0", bus.enter[0], bus.count); end
    step2(2'b00, 2'b00);
    n_checks++; if (bus.enter[0] !== 1'b0 || bus.count !== 7'd1) begin n_fail++; $display("FAIL entry_count: got enter %b count %0d expected 0 1", bus.enter[0], bus.count); end
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL entry_empty: got %b expected 0", bus.empty); end
    step2(2'b00, 2'b00);
    n_checks++; if (obs_enter[0] !== 1 || obs_abort[0] !== 0) begin n_fail++; $display("FAIL entry_once: got enters %0d aborts %0d expected 1 0", obs_enter[0], obs_abort[0]); end
  endtask

  task automatic test_exit();
    clear_obs();
    step2(2'b00, 2'b01); step2(2'b00, 2'b11); step2(2'b00, 2'b10); step2(2'b00, 2'b00);
    n_checks++; if (bus.exit[1] !== 1'b1) begin n_fail++; $display("FAIL exit_pulse: got %b expected 1", bus.exit[1]); end
    step2(2'b00, 2'b00);
    n_checks++; if (bus.count !== 7'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL exit_count: got count %0d empty %b expected 0 1", bus.count, bus.empty); end
    n_checks++; if (bus.under_err !== 1'b0) begin n_fail++; $display("FAIL exit_no_under: got %b expected 0", bus.under_err); end
    step2(2'b00, 2'b01); step2(2'b00, 2'b11); step2(2'b00, 2'b10); step2(2'b00, 2'b00);
    step2(2'b00, 2'b00);
    n_checks++; if (bus.under_err !== 1'b1 || bus.count !== 7'd0) begin n_fail++; $display("FAIL under_sat: got under %b count %0d expected 1 0", bus.under_err, bus.count); end
    step2(2'b00, 2'b00);
    n_checks++; if (bus.under_err !== 1'b0) begin n_fail++; $display("FAIL under_one_cycle: got %b expected 0", bus.under_err); end
    n_checks++; if (obs_exit[1] !== 2) begin n_fail++; $display("FAIL exit_total: got %0d expected 2", obs_exit[1]); end
  endtask

  task automatic test_backout_abort();
    clear_obs();
    step2(2'b00, 2'b00); step2(2'b10, 2'b00); step2(2'b00, 2'b00); step2(2'b00, 2'b00);
    n_checks++; if (obs_enter[0] !== 0 || bus.count !== 7'd0) begin n_fail++; $display("FAIL backout: got enters %0d count %0d expected 0 0", obs_enter[0], bus.count); end
    step2(2'b11, 2'b00);
    n_checks++; if (bus.abort[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b expected 1", bus.abort[0]); end
    step2(2'b00, 2'b00); step2(2'b00, 2'b00);
    n_checks++; if (obs_abort[0] !== 1 || bus.count !== 7'd0 || bus.under_err !== 1'b0) begin n_fail++; $display("FAIL abort_once: got aborts %0d count %0d under %b expected 1 0 0", obs_abort[0], bus.count, bus.under_err); end
  endtask

  task automatic test_simultaneous();
    for (int n = 0; n < 5; n++) begin
      step2(2'b10, 2'b00); step2(2'b11, 2'b00); step2(2'b01, 2'b00); step2(2'b00, 2'b00);
    end
    step2(2'b00, 2'b00);
    n_checks++; if (bus.count !== 7'd5) begin n_fail++; $display("FAIL five_entries: got %0d expected 5", bus.count); end
    step2(2'b10, 2'b01); step2(2'b11, 2'b11); step2(2'b01, 2'b10); step2(2'b00, 2'b00);
    n_checks++; if (bus.enter !== 2'b01 || bus.exit !== 2'b10) begin n_fail++; $display("FAIL simul_pulses: got enter %b exit %b expected 01 10", bus.enter, bus.exit); end
    step2(2'b00, 2'b00);
    n_checks++; if (bus.count !== 7'd5 || bus.over_err !== 1'b0 || bus.under_err !== 1'b0) begin n_fail++; $display("FAIL simul_net: got count %0d over %b under %b expected 5 0 0", bus.count, bus.over_err, bus.under_err); end
  endtask

  task automatic test_capacity();
    for (int k = 1; k <= 4; k++) begin
      cap_step(2'b10); cap_step(2'b11); cap_step(2'b01); cap_step(2'b00); cap_step(2'b00);
      n_checks++;
      if (int'(bus3.count) !== ((k < CAP3) ? k : CAP3) || bus3.full !== (k >= CAP3) || bus3.over_err !== (k == 4)) begin
        n_fail++;
        $display("FAIL cap_entry%0d: got count %0d full %b over %b expected %0d %b %b",
                 k, bus3.count, bus3.full, bus3.over_err, (k < CAP3) ? k : CAP3, k >= CAP3, k == 4);
      end
    end
    cap_step(2'b00);
    n_checks++; if (bus3.over_err !== 1'b0 || bus3.count !== 2'd3) begin n_fail++; $display("FAIL cap_over_one_cycle: got over %b count %0d expected 0 3", bus3.over_err, bus3.count); end
  endtask

  task automatic test_reset_mid();
    step2(2'b10, 2'b00); step2(2'b11, 2'b00);
    step2(2'b11, 2'b00, 1'b1);
    n_checks++; if (bus.count !== 7'd0 || bus.empty !== 1'b1 || bus3.count !== 2'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d/%0d expected 0/0", bus.count, bus3.count); end
    clear_obs();
    step2(2'b01, 2'b00); step2(2'b00, 2'b00); step2(2'b00, 2'b00);
    n_checks++; if (obs_enter[0] !== 0 || bus.count !== 7'd0) begin n_fail++; $display("FAIL mid_reset_discard: got enters %0d count %0d expected 0 0", obs_enter[0], bus.count); end
  endtask

  task automatic test_random();
    logic [1:0] p[NL];
    int shown = 0;
    step2(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < NL; i++) p[i] = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      bit rst;
      for (int i = 0; i < NL; i++)
        if ($urandom_range(0, 99) < 45) p[i] = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) == 0);
      step2(p[0], p[1], rst);
      n_checks++;
      if (bus.enter !== m_enter || bus.exit !== m_exit || bus.abort !== m_abort ||
          int'(bus.count) !== m_count || bus.full !== (m_count == CAP) || bus.empty !== (m_count == 0) ||
          bus.over_err !== m_over || bus.under_err !== m_under) begin
        n_fail++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cycle%0d: got en %b ex %b ab %b cnt %0d f %b e %b ov %b un %b expected en %b ex %b ab %b cnt %0d f %b e %b ov %b un %b",
                   c, bus.enter, bus.exit, bus.abort, bus.count, bus.full, bus.empty, bus.over_err, bus.under_err,
                   m_enter, m_exit, m_abort, m_count, m_count == CAP, m_count == 0, m_over, m_under);
        end
      end
    end
  endtask

  initial begin
    bus.a = '0; bus.b = '0; bus3.a = '0; bus3.b = '0; reset = 1'b1;
    test_reset();
    test_entry();
    test_exit();
    test_backout_abort();
    test_simultaneous();
    test_capacity();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
